// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector load/store sequencer.
// Holds the decode opcode encodings, vector geometry, instruction field
// widths, the sequencer state enum and a small opcode helper.
package vec_pkg;

  // Vector geometry
  localparam int VLEN  = 16;
  localparam int IDX_W = $clog2(VLEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  // Decoded instruction field widths
  localparam int OP_W  = 4;
  localparam int REG_W = 3;
  localparam int OFF_W = 6;

  // Opcode encodings shared with instruction decode
  localparam logic [OP_W-1:0] VADD = 4'b0000;
  localparam logic [OP_W-1:0] VDOT = 4'b0001;
  localparam logic [OP_W-1:0] SMUL = 4'b0010;
  localparam logic [OP_W-1:0] SST  = 4'b0011;
  localparam logic [OP_W-1:0] VLD  = 4'b0100;
  localparam logic [OP_W-1:0] VST  = 4'b0101;
  localparam logic [OP_W-1:0] SLL  = 4'b0110;
  localparam logic [OP_W-1:0] SLH  = 4'b0111;
  localparam logic [OP_W-1:0] J    = 4'b1000;
  localparam logic [OP_W-1:0] NOP  = 4'b1111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_LOAD_DRAIN = 2'd2,
    ST_STORE      = 2'd3
  } seq_state_e;

  // Instruction fields captured when a transfer is accepted
  typedef struct packed {
    logic [REG_W-1:0] dst;  // VLD destination vector register
    logic [REG_W-1:0] src;  // VST source vector register
    logic [OFF_W-1:0] off;  // raw two's-complement element offset
  } xfer_fields_t;

  // State entered from IDLE when an instruction with this opcode is
  // accepted; anything that is not a vector memory op retires in place.
  function automatic seq_state_e start_state(input logic [OP_W-1:0] op);
    seq_state_e st;
    case (op)
      VLD:     st = ST_LOAD;
      VST:     st = ST_STORE;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/vec_agu.sv
// vec_agu: element address generator.
// addr = base + sext(offset) + idx, truncated to ADDR_W bits so that the
// sum wraps silently at the top of the address space.
module vec_agu
  import vec_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] off_sext;
  logic [ADDR_W-1:0] idx_ext;

  // Widen both operands to the address width, then add modulo 2^ADDR_W
  always_comb begin
    off_sext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
    idx_ext  = {{(ADDR_W-IDX_W){1'b0}}, idx};
    addr     = base + off_sext + idx_ext;
  end

endmodule

// File: rtl/vec_seq.sv
// vec_seq: multi-cycle vector load/store sequencer.
// Accepts one decoded instruction at a time while IDLE. VLD streams VLEN
// element reads from data memory into a vector register (the read data
// returns one cycle after the request, so the VRF writes trail by one cycle
// and a drain state writes the last element). VST streams VLEN elements
// from a vector register to memory. Other opcodes retire immediately.
// Optional build macro: VSEQ_FLUSH_EN adds a 'flush' input that squashes
// all side effects combinationally and returns the sequencer to IDLE.
module vec_seq
  import vec_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef VSEQ_FLUSH_EN
  input  logic              flush,
`endif
  // Decode handshake and fields
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   functype,
  input  logic [REG_W-1:0]  dst_addr,
  input  logic [REG_W-1:0]  addr2,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] base_addr,
  // Data memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // VRF read port (combinational)
  output logic [REG_W-1:0]  vrf_rd_addr,
  output logic [IDX_W-1:0]  vrf_rd_elem,
  input  logic [DATA_W-1:0] vrf_rd_data,
  // VRF write port
  output logic              vrf_we,
  output logic [REG_W-1:0]  vrf_wr_addr,
  output logic [IDX_W-1:0]  vrf_wr_elem,
  output logic [DATA_W-1:0] vrf_wr_data,
  // Pipeline control
  output logic              stall,
  output logic              done
);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  xfer_fields_t      fields_q, fields_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              flush_active;
  logic              accept;
  logic              last_elem;
  logic [ADDR_W-1:0] agu_addr;

`ifdef VSEQ_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  // Handshake: only an idle, un-flushed sequencer takes a new instruction
  assign dec_ready = (state_q == ST_IDLE) && !flush_active;
  assign accept    = dec_valid && dec_ready;
  assign last_elem = (idx_q == LAST_IDX);

  // Stall follows the state register directly so fetch freezes from the
  // first transfer cycle through the cycle that pulses done.
  assign stall = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------
  vec_agu #(
    .ADDR_W (ADDR_W)
  ) u_agu (
    .base   (base_q),
    .offset (fields_q.off),
    .idx    (idx_q),
    .addr   (agu_addr)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // Hold the sequencer state; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: flops use non-blocking assignment so every register samples
      // pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // Walk IDLE -> LOAD -> LOAD_DRAIN -> IDLE or IDLE -> STORE -> IDLE
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the signal
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = start_state(functype);
        end
      end
      ST_LOAD: begin
        if (last_elem) begin
          state_d = ST_LOAD_DRAIN;
        end
      end
      ST_LOAD_DRAIN: begin
        state_d = ST_IDLE;
      end
      ST_STORE: begin
        if (last_elem) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush_active) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // Decode memory/VRF enables and the done pulse from the current state
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    vrf_we      = 1'b0;
    done        = 1'b0;
    // In LOAD the element being written is the one requested last cycle
    vrf_wr_elem = idx_q - IDX_W'(1);
    unique case (state_q)
      ST_LOAD: begin
        mem_req = 1'b1;
        // The first LOAD cycle has no read data returning yet
        vrf_we  = (idx_q != '0);
      end
      ST_LOAD_DRAIN: begin
        vrf_we      = 1'b1;
        vrf_wr_elem = LAST_IDX;
        done        = 1'b1;
      end
      ST_STORE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        done    = last_elem;
      end
      default: begin
      end
    endcase
    // Flush squashes every side effect in the same cycle, including a
    // read return still owed to the VRF
    if (flush_active) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      vrf_we  = 1'b0;
      done    = 1'b0;
    end
  end

  // Address and data paths are don't-care while their enables are low, so
  // they are driven unconditionally from the latched fields and counter.
  assign mem_addr    = agu_addr;
  assign mem_wdata   = vrf_rd_data;
  assign vrf_rd_addr = fields_q.src;
  assign vrf_rd_elem = idx_q;
  assign vrf_wr_addr = fields_q.dst;
  assign vrf_wr_data = mem_rdata;

  // ---------------------------------------------------------------------
  // Datapath: element counter and latched instruction fields
  // ---------------------------------------------------------------------
  // Capture fields on accept; advance the element index while transferring
  always_comb begin
    idx_d    = idx_q;
    fields_d = fields_q;
    base_d   = base_q;
    if (accept) begin
      idx_d        = '0;
      fields_d.dst = dst_addr;
      fields_d.src = addr2;
      fields_d.off = offset;
      base_d       = base_addr;
    end else if ((state_q == ST_LOAD) || (state_q == ST_STORE)) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Register the counter and the captured instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the captured fields are reset as well; they feed the address
      // and VRF port outputs, which should read as zero out of reset.
      idx_q    <= '0;
      fields_q <= '0;
      base_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      fields_q <= fields_d;
      base_q   <= base_d;
    end
  end

endmodule

// File: tb/tb_vec_seq.sv
// tb_vec_seq: scoreboard bench for vec_seq.
// A driver issues instructions and, on each accept, a transaction-level
// model pushes every expected memory request, VRF write and done pulse
// (with its cycle number) into queues. A negedge monitor pops and compares
// whenever the DUT asserts an enable, and flags any enable it did not
// expect. Stall/dec_ready are compared every cycle against the busy window.
module tb_vec_seq;
  import vec_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
`ifdef VSEQ_FLUSH_EN
  logic              flush;
`endif
  logic              dec_valid;
  logic              dec_ready;
  logic [OP_W-1:0]   functype;
  logic [REG_W-1:0]  dst_addr;
  logic [REG_W-1:0]  addr2;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [REG_W-1:0]  vrf_rd_addr;
  logic [IDX_W-1:0]  vrf_rd_elem;
  logic [DATA_W-1:0] vrf_rd_data;
  logic              vrf_we;
  logic [REG_W-1:0]  vrf_wr_addr;
  logic [IDX_W-1:0]  vrf_wr_elem;
  logic [DATA_W-1:0] vrf_wr_data;
  logic              stall;
  logic              done;

  vec_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef VSEQ_FLUSH_EN
    .flush       (flush),
`endif
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .functype    (functype),
    .dst_addr    (dst_addr),
    .addr2       (addr2),
    .offset      (offset),
    .base_addr   (base_addr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .vrf_rd_addr (vrf_rd_addr),
    .vrf_rd_elem (vrf_rd_elem),
    .vrf_rd_data (vrf_rd_data),
    .vrf_we      (vrf_we),
    .vrf_wr_addr (vrf_wr_addr),
    .vrf_wr_elem (vrf_wr_elem),
    .vrf_wr_data (vrf_wr_data),
    .stall       (stall),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  rg;
    logic [3:0]  elem;
  } ev_t;

  ev_t rd_q[$];
  ev_t st_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [15:0] salt = 16'h0000;
  logic        vrf_init;

  logic [15:0] ref_vrf [8][16];
  logic [15:0] vrf_mem [8][16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Environment: data memory returns 0xA000 + addr + salt one cycle after
  // a read request; the VRF is a plain array written by the DUT.
  // ---------------------------------------------------------------------
  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= 16'hA000 + mem_addr + salt;
  end

  always @(posedge clk) begin
    if (vrf_init) vrf_mem <= ref_vrf;
    else if (vrf_we) vrf_mem[vrf_wr_addr][vrf_wr_elem] <= vrf_wr_data;
  end

  assign vrf_rd_data = vrf_mem[vrf_rd_addr][vrf_rd_elem];

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    ev_t  e;
    int   dc;
    logic busy;
    busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    check("stall", 64'(stall), 64'(busy));
    check("dec_ready", 64'(dec_ready), 64'(!busy));
    if (mem_req && mem_we) begin
      if (st_q.size() == 0) check("store_unexpected", 64'(mem_req), 64'd0);
      else begin
        e = st_q.pop_front();
        check("store", 64'({16'(cyc), mem_addr, mem_wdata}), 64'({16'(e.cyc), e.addr, e.data}));
      end
    end
    if (mem_req && !mem_we) begin
      if (rd_q.size() == 0) check("read_unexpected", 64'(mem_req), 64'd0);
      else begin
        e = rd_q.pop_front();
        check("read", 64'({16'(cyc), mem_addr}), 64'({16'(e.cyc), e.addr}));
      end
    end
    if (vrf_we) begin
      if (wr_q.size() == 0) check("vrf_wr_unexpected", 64'(vrf_we), 64'd0);
      else begin
        e = wr_q.pop_front();
        check("vrf_wr", 64'({16'(cyc), vrf_wr_addr, vrf_wr_elem, vrf_wr_data}),
              64'({16'(e.cyc), e.rg, e.elem, e.data}));
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", 64'(done), 64'd0);
      else begin
        dc = done_q.pop_front();
        check("done", 64'(cyc), 64'(dc));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver + reference model
  // ---------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, then push the
  // whole expected transaction. Returns the accept cycle or -1.
  task automatic issue(input logic [3:0] ft, input logic [2:0] d, input logic [2:0] s,
                       input logic [5:0] off, input logic [15:0] base,
                       input logic [15:0] new_salt, output int t_acc);
    int          waited;
    logic [15:0] a;
    ev_t         e;
    functype  = ft;
    dst_addr  = d;
    addr2     = s;
    offset    = off;
    base_addr = base;
    dec_valid = 1'b1;
    t_acc     = -1;
    waited    = 0;
    while (t_acc < 0 && waited < 100) begin
      @(negedge clk);
      if (dec_ready) t_acc = cyc;
      else waited++;
    end
    if (t_acc < 0) begin
      check("accept_timeout", 64'(dec_ready), 64'd1);
      dec_valid = 1'b0;
      return;
    end
    if (ft == VLD) begin
      salt = new_salt;
      for (int i = 0; i < VLEN; i++) begin
        a      = base + {{10{off[5]}}, off} + 16'(i);
        e.cyc  = t_acc + 1 + i;
        e.addr = a;
        e.data = 16'h0;
        e.rg   = 3'd0;
        e.elem = 4'd0;
        rd_q.push_back(e);
        e.cyc  = t_acc + 2 + i;
        e.data = 16'hA000 + a + new_salt;
        e.rg   = d;
        e.elem = 4'(i);
        wr_q.push_back(e);
        ref_vrf[d][i] = e.data;
      end
      done_q.push_back(t_acc + 17);
      busy_lo = t_acc + 1;
      busy_hi = t_acc + 17;
    end else if (ft == VST) begin
      for (int i = 0; i < VLEN; i++) begin
        e.cyc  = t_acc + 1 + i;
        e.addr = base + {{10{off[5]}}, off} + 16'(i);
        e.data = ref_vrf[s][i];
        e.rg   = 3'd0;
        e.elem = 4'd0;
        st_q.push_back(e);
      end
      done_q.push_back(t_acc + 16);
      busy_lo = t_acc + 1;
      busy_hi = t_acc + 16;
    end
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
  endtask

  logic [3:0] others [8];

  initial begin : stim
    int t1, t2, g;
    int pick;
    logic [3:0] ft;
    others = '{VADD, VDOT, SMUL, SST, SLL, SLH, J, NOP};
    rst_n     = 1'b0;
`ifdef VSEQ_FLUSH_EN
    flush     = 1'b0;
`endif
    dec_valid = 1'b0;
    functype  = NOP;
    dst_addr  = '0;
    addr2     = '0;
    offset    = '0;
    base_addr = '0;
    mem_rdata = '0;
    vrf_init  = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 16; k++) ref_vrf[r][k] = 16'($urandom);

    // Reset values
    idle(3);
    check("rst_dec_ready", 64'(dec_ready), 64'd1);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_vrf_we", 64'(vrf_we), 64'd0);
    vrf_init = 1'b0;
    #1 rst_n = 1'b1;
    idle(2);

    // Directed: basic VLD, VST with negative offset, wrapping VLD, no-op
    issue(VLD, 3'd3, 3'd0, 6'h02, 16'h0100, 16'h0000, t1);
    idle(20);
    issue(VST, 3'd0, 3'd2, 6'h3F, 16'h00F8, 16'h0000, t1);
    idle(20);
    issue(VLD, 3'd5, 3'd0, 6'h00, 16'hFFFC, 16'($urandom), t1);
    idle(20);
    issue(VADD, 3'd1, 3'd1, 6'h05, 16'h1234, 16'h0000, t1);
    idle(3);

    // VLD held valid during a VST: accepted the cycle after done
    issue(VST, 3'd0, 3'd3, 6'h01, 16'h0200, 16'h0000, t1);
    issue(VLD, 3'd6, 3'd0, 6'h10, 16'h0300, 16'($urandom), t2);
    check("b2b_accept", 64'(t2), 64'(t1 + 17));
    idle(20);

    // Randomized mix, gap 0 keeps dec_valid asserted back to back
    for (int n = 0; n < 24; n++) begin
      pick = $urandom_range(0, 3);
      if (pick == 0)      ft = VLD;
      else if (pick == 1) ft = VST;
      else                ft = others[$urandom_range(0, 7)];
      issue(ft, 3'($urandom), 3'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), t1);
      g = $urandom_range(0, 3);
      if (g > 0) idle(g);
    end

    // Drain outstanding expectations (bounded)
    g = 0;
    while ((rd_q.size() + st_q.size() + wr_q.size() + done_q.size()) != 0 && g < 100) begin
      idle(1);
      g++;
    end
    check("drain_left", 64'(rd_q.size() + st_q.size() + wr_q.size() + done_q.size()), 64'd0);
    idle(2);

    // Reset asserted at VST element 7
    issue(VST, 3'd0, 3'd4, 6'h00, 16'h0400, 16'h0000, t1);
    g = 0;
    while (cyc != t1 + 8 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("reset_reach_elem7", 64'(cyc), 64'(t1 + 8));
    #1;
    rd_q.delete();
    st_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    rst_n   = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_mem_we", 64'(mem_we), 64'd0);
    check("midrst_dec_ready", 64'(dec_ready), 64'd1);
    check("midrst_stall", 64'(stall), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vec_seq.md
# vec_seq

Multi-cycle vector load/store sequencer that consumes decoded instruction fields and runs the 16-element memory transfers for VLD and VST. It sits between instruction decode and the vector register file (VRF) and data memory. It holds the pipeline stalled while a transfer is in flight. All other opcodes are accepted and retired in one cycle with no action.

## Interface
- VLEN, 16, elements per vector; element index width is $clog2(VLEN)
- ADDR_W, 16, data memory address width
- DATA_W, 16, element and memory data width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  sequencer can accept (high only in IDLE)
- functype  in  4  opcode: VLD=4'b0100, VST=4'b0101, others are no-ops here
- dst_addr  in  3  VLD destination vector register
- addr2  in  3  VST source vector register
- offset  in  6  two's-complement element offset
- base_addr  in  ADDR_W  scalar base value, already read from the register file
- mem_req / mem_we  out  1 / 1  memory request / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid the cycle after mem_req
- vrf_rd_addr / vrf_rd_elem  out  3 / 4  VRF read port (combinational read)
- vrf_rd_data  in  DATA_W  VRF read data
- vrf_we  out  1  VRF element write enable
- vrf_wr_addr / vrf_wr_elem  out  3 / 4  VRF write register / element
- vrf_wr_data  out  DATA_W  VRF write data
- stall  out  1  freeze PC/fetch; high whenever state != IDLE
- done  out  1  one-cycle pulse in the final cycle of a VLD/VST

## Operation
- **Accept:** dec_valid & dec_ready at a cycle edge (call it cycle T).
  - Latch opcode, dst_addr, addr2, base_addr and sign-extended offset.
  - Clear the element counter idx.
- **Address:** mem_addr = base + sext(offset) + idx, computed mod 2^ADDR_W (wraps silently).
- **States:** IDLE, LOAD, LOAD_DRAIN, STORE.
  - IDLE -> LOAD on accepted VLD.
  - IDLE -> STORE on accepted VST.
  - IDLE -> IDLE on any other opcode: consumed, no outputs asserted, no done.
  - LOAD: mem_req=1, mem_we=0, idx increments each cycle. After idx=VLEN-1 -> LOAD_DRAIN.
  - LOAD writes: from the second LOAD cycle on, vrf_we=1, vrf_wr_addr=latched dst, vrf_wr_elem=idx-1, vrf_wr_data=mem_rdata.
  - LOAD_DRAIN: writes element VLEN-1, done=1, then -> IDLE.
  - STORE: mem_req=1, mem_we=1, vrf_rd_addr=latched addr2, vrf_rd_elem=idx, mem_wdata=vrf_rd_data.
  - STORE exit: done=1 when idx=VLEN-1, then -> IDLE.
- **Outputs when inactive:** mem_req, mem_we, vrf_we and done are 0 outside the states above. Address and data outputs are don't-care when their enables are low.
- **Input holding:** dec_valid held during a transfer is ignored (dec_ready=0). It is accepted the cycle after done.
- **Reset:** async assert forces IDLE and idx=0 at any point, including mid-transfer. The partial transfer is abandoned and no further writes occur.
  - Reset values: dec_ready=1, stall=0, done=0, mem_req=0, mem_we=0, vrf_we=0.
  - All registered fields reset to 0.

## Timing
- VLD:
  - Requests in T+1..T+16, element i addressed in T+1+i.
  - VRF writes in T+2..T+17.
  - done in T+17; dec_ready high in T+18.
- VST:
  - Writes in T+1..T+16.
  - done in T+16; dec_ready high in T+17.
- Non-vector opcode: accepted in T; dec_ready stays 1 and stall stays 0.
- stall is combinational from state. It rises in T+1 and falls the cycle after done.

## Configuration
- VSEQ_FLUSH_EN defined: adds input flush (1 bit). flush=1 in any cycle forces mem_req, mem_we, vrf_we and done to 0 combinationally, and sets state to IDLE at the next edge.
  - A pending LOAD read return is discarded.
  - flush in IDLE blocks acceptance that cycle (dec_ready=0).
- VSEQ_FLUSH_EN undefined: no flush port; transfers always run to completion.

## Structure
- Shared package vec_pkg holds:
  - opcode localparams (VADD, VDOT, SMUL, SST, VLD, VST, SLL, SLH, J, NOP with the same 4-bit encodings as decode);
  - the sequencer state enum;
  - VLEN.
- One sub-module, vec_agu: combinational base + sext(offset) + idx adder with wrap.

## Test plan
- Reset, then VLD base=0x0100, offset=6'h02, dst=3, mem_rdata=0xA000+addr -> mem_addr 0x0102..0x0111 in T+1..T+16; v3 elements 0..15 = 0xA102..0xA111 in T+2..T+17; done only in T+17.
- VST base=0x00F8, offset=6'h3F (-1), addr2=2 -> mem_we=1 at 0x00F7..0x0106; mem_wdata = v2[i]; done in T+16; stall low in T+17.
- VLD base=0xFFFC, offset=0 -> addresses 0xFFFC..0xFFFF then 0x0000..0x000B.
- dec_valid with functype=VADD in IDLE -> no mem_req, no vrf_we, no done; stall stays 0.
- Second VLD held valid during a VST -> dec_ready=0 until done; second VLD accepted the cycle after done.
- rst_n low at VST element 7 -> mem_req=0 immediately, dec_ready=1, stall=0; no writes after release until a new accept.
